// File: rtl/d0fifo_drain.sv
// Drain stage for the zero-latency d0fifo: 2-entry skid buffer re-presenting popped words as a valid/ready stream.
// Optional beat counter on out_cnt is built only when D0FIFO_DRAIN_CNT_EN is defined.
module d0fifo_drain #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_pop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           count;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             running;
  logic             enq;
  logic             deq;

  // running keeps fifo_pop low while rst_n is asserted without putting reset in the pop path
  assign fifo_pop  = running && !fifo_empty && (count != TWO) && !flush;
  assign enq       = fifo_pop && fifo_valid;
  assign out_valid = (count != EMPTY);
  assign deq       = out_valid && out_ready;
  assign out_data  = slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= EMPTY;
      slot0   <= '0;
      slot1   <= '0;
      running <= 1'b0;
      err     <= 1'b0;
    end else begin
      running <= 1'b1;
      if (fifo_valid && !fifo_pop) begin
        err <= 1'b1;
      end
      if (flush) begin
        count <= EMPTY;
        slot0 <= '0;
        slot1 <= '0;
      end else begin
        unique case (count)
          EMPTY: begin
            if (enq) begin
              slot0 <= fifo_rdata;
              count <= ONE;
            end
          end
          ONE: begin
            if (enq && deq) begin
              slot0 <= fifo_rdata;
            end else if (enq) begin
              slot1 <= fifo_rdata;
              count <= TWO;
            end else if (deq) begin
              count <= EMPTY;
            end
          end
          TWO: begin
            if (deq) begin
              slot0 <= slot1;
              count <= ONE;
            end
          end
          default: begin
            count <= EMPTY;
          end
        endcase
      end
    end
  end

`ifdef D0FIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] beat_cnt;

  // Counts every handshake, including one taken in a flush cycle; flush never clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (deq) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign out_cnt = beat_cnt;
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_d0fifo_drain.sv
// Directed testbench for d0fifo_drain with a small zero-latency FIFO model feeding it.
// Run with D0FIFO_DRAIN_CNT_EN defined or not; the counter expectation follows the macro.
module tb_d0fifo_drain;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
`ifdef D0FIFO_DRAIN_CNT_EN
  localparam logic [CNT_W-1:0] CNT_AFTER_17 = 4'd1;
`else
  localparam logic [CNT_W-1:0] CNT_AFTER_17 = 4'd0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_pop;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             err;

  logic [WIDTH-1:0] mem [0:31];
  logic [4:0]       wr_ptr = '0;
  logic [4:0]       rd_ptr = '0;
  logic             inject_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  d0fifo_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Zero-latency FIFO model: data and accept strobe in the same cycle as the pop
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_valid = (fifo_pop && !fifo_empty) || inject_valid;
  assign fifo_rdata = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_pop && fifo_valid && !fifo_empty) rd_ptr <= rd_ptr + 5'd1;
  end

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop got %b want 0", fifo_pop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h want 0000", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (out_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", out_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        errors++; $display("[TB] FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, WIDTH'(i));
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    tick();
    tick();
    checks++; if (out_data !== 16'h00A1 || fifo_pop !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_two got d=%h pop=%b want d=00a1 pop=0", out_data, fifo_pop); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00A1) begin
      errors++; $display("[TB] FAIL bp_stable got v=%b d=%h want v=1 d=00a1", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 16'h00A2) begin errors++; $display("[TB] FAIL bp_second got %h want 00a2", out_data); end
    tick();
    checks++; if (out_data !== 16'h00A3) begin errors++; $display("[TB] FAIL bp_third got %h want 00a3", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_enq_deq();
    out_ready = 1'b0;
    push(16'h0044);
    tick();
    checks++; if (out_data !== 16'h0044) begin errors++; $display("[TB] FAIL ed_one got %h want 0044", out_data); end
    out_ready = 1'b1;
    push(16'h0055);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0055) begin
      errors++; $display("[TB] FAIL ed_swap got v=%b d=%h want v=1 d=0055", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ed_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(16'h00B1); push(16'h00B2); push(16'h00B3);
    tick();
    tick();
    flush = 1'b1;
    #1;
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL flush_pop got %b want 0", fifo_pop); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", out_valid); end
    #1;
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL flush_resume_pop got %b want 1", fifo_pop); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00B3) begin
      errors++; $display("[TB] FAIL flush_resume got v=%b d=%h want v=1 d=00b3", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_err();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clean got %b want 0", err); end
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b want 1", err); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    push(16'h00C1); push(16'h00C2); push(16'h00C3);
    tick();
    checks++; if (out_data !== 16'h00C1) begin errors++; $display("[TB] FAIL mr_loaded got %h want 00c1", out_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || err !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++; $display("[TB] FAIL mr_outputs got v=%b d=%h e=%b pop=%b want 0 0000 0 0", out_valid, out_data, err, fifo_pop); end
    wr_ptr = rd_ptr;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(16'h0100 + WIDTH'(i));
    for (int i = 0; i < 19; i++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL cnt_drained got %b want 0", out_valid); end
    checks++; if (out_cnt !== CNT_AFTER_17) begin
      errors++; $display("[TB] FAIL cnt_wrap got %0d want %0d", out_cnt, CNT_AFTER_17); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_enq_deq();
    test_flush();
    test_err();
    test_mid_reset();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
